// File: rtl/led_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : led_bank_arbiter
//  Description : Round-robin sharing of the LED bank between NREQ status
//                sources, with a minimum hold time counted in prescaler ticks.
//  Revision    : 1.0  initial release
// ============================================================================
module led_bank_arbiter #(
    parameter int NREQ       = 4,
    parameter int LED_W      = 6,
    parameter int PRESCALE_W = 23,
    parameter int HOLD_TICKS = 4
) (
    input  logic                    clk50,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LED_W-1:0]   pattern,
    output logic [NREQ-1:0]         grant,
    output logic [LED_W-1:0]        leds,
    output logic                    blink,
    output logic                    busy
);

    localparam int                  c_OWNER_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int                  c_HOLD_W   = $clog2(HOLD_TICKS + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(HOLD_TICKS);
    localparam logic [c_OWNER_W-1:0] c_LAST_RST = c_OWNER_W'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OWN    = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    state_t                  r_state;
    logic [PRESCALE_W-1:0]   r_prescaler;
    logic [c_HOLD_W-1:0]     r_hold_cnt;
    logic [c_OWNER_W-1:0]    r_last_owner;
    logic [NREQ-1:0]         r_grant;
    logic [LED_W-1:0]        r_leds;
    logic                    r_blink;

    state_t                  w_state_nxt;
    logic [c_HOLD_W-1:0]     w_hold_nxt;
    logic [c_HOLD_W-1:0]     w_hold_inc;
    logic [c_OWNER_W-1:0]    w_last_nxt;
    logic [NREQ-1:0]         w_grant_nxt;
    logic [LED_W-1:0]        w_leds_nxt;
    logic                    w_blink_nxt;

    logic                    w_tick;
    logic                    w_any_req;
    logic [c_OWNER_W-1:0]    w_sel;
    logic [NREQ-1:0]         w_sel_onehot;
    logic [NREQ-1:0]         w_owner_mask;
    logic                    w_owner_req;
    logic                    w_other_req;
    logic [LED_W-1:0]        w_owner_pat;
    logic                    w_leave;

    assign w_tick       = &r_prescaler;
    assign w_any_req    = |req;
    assign w_sel_onehot = NREQ'(1) << w_sel;
    assign w_owner_mask = NREQ'(1) << r_last_owner;
    assign w_owner_req  = |(req & w_owner_mask);
    assign w_other_req  = |(req & ~w_owner_mask);
    assign w_owner_pat  = pattern[int'(r_last_owner) * LED_W +: LED_W];
    assign w_hold_inc   = (r_hold_cnt == c_HOLD_MAX) ? r_hold_cnt
                                                     : r_hold_cnt + c_HOLD_W'(1);
    // An owner leaves when it lets go, or when its hold is served and someone waits.
    assign w_leave      = !w_owner_req || ((r_hold_cnt == c_HOLD_MAX) && w_other_req);

    // Scan downward so the nearest requester after the last owner wins.
    always_comb begin
        w_sel = r_last_owner;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(r_last_owner) + k) % NREQ]) begin
                w_sel = c_OWNER_W'((int'(r_last_owner) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_leds_nxt  = r_leds;
        w_blink_nxt = r_blink;
        w_hold_nxt  = r_hold_cnt;
        w_last_nxt  = r_last_owner;
        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                w_leds_nxt  = '0;
                w_blink_nxt = 1'b0;
                if (w_any_req) begin
                    w_state_nxt = S_OWN;
                    w_grant_nxt = w_sel_onehot;
                    w_last_nxt  = w_sel;
                    w_hold_nxt  = '0;
                end
            end
            S_OWN: begin
                w_leds_nxt = w_owner_pat;
                if (w_tick) begin
                    w_blink_nxt = ~r_blink;
                    w_hold_nxt  = w_hold_inc;
                end
                if (w_leave) begin
                    w_state_nxt = S_SWITCH;
                    w_grant_nxt = '0;
                end
            end
            S_SWITCH: begin
                w_grant_nxt = '0;
                if (w_any_req) begin
                    w_state_nxt = S_OWN;
                    w_grant_nxt = w_sel_onehot;
                    w_last_nxt  = w_sel;
                    w_hold_nxt  = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_leds_nxt  = '0;
                    w_blink_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_leds_nxt  = '0;
                w_blink_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_prescaler  <= '0;
            r_hold_cnt   <= '0;
            r_last_owner <= c_LAST_RST;
            r_grant      <= '0;
            r_leds       <= '0;
            r_blink      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prescaler  <= r_prescaler + PRESCALE_W'(1);
            r_hold_cnt   <= w_hold_nxt;
            r_last_owner <= w_last_nxt;
            r_grant      <= w_grant_nxt;
            r_leds       <= w_leds_nxt;
            r_blink      <= w_blink_nxt;
        end
    end

    assign grant = r_grant;
    assign leds  = r_leds;
    assign blink = r_blink;
    assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_led_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_bank_arbiter
//  Description : Vector table, corner sequences and random run against a
//                behavioural model of the LED bank arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_bank_arbiter;

    localparam int NREQ       = 4;
    localparam int LED_W      = 6;
    localparam int PRESCALE_W = 2;
    localparam int HOLD_TICKS = 2;
    localparam int PER        = 1 << PRESCALE_W;
    localparam logic [23:0] P1 = {6'h33, 6'h2A, 6'h22, 6'h11};
    localparam logic [23:0] P2 = {6'h33, 6'h2A, 6'h22, 6'h3F};

    logic        clk50 = 1'b0;
    logic        rst   = 1'b1;
    logic [3:0]  req   = 4'h0;
    logic [23:0] pattern = 24'h0;
    logic [3:0]  grant;
    logic [5:0]  leds;
    logic        blink;
    logic        busy;

    always #5 clk50 = ~clk50;

    led_bank_arbiter #(
        .NREQ       (NREQ),
        .LED_W      (LED_W),
        .PRESCALE_W (PRESCALE_W),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clk50   (clk50),
        .rst     (rst),
        .req     (req),
        .pattern (pattern),
        .grant   (grant),
        .leds    (leds),
        .blink   (blink),
        .busy    (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 = idle, 1 = owned, 2 = handover cycle
    int         m_mode  = 0;
    int         m_last  = NREQ - 1;
    int         m_hold  = 0;
    int         m_since = 0;
    logic [3:0] m_grant = 4'h0;
    logic [5:0] m_leds  = 6'h0;
    logic       m_blink = 1'b0;

    function automatic int rr_pick(input int last, input logic [3:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return last;
    endfunction

    task automatic model_grant(input logic [3:0] a_req);
        m_last  = rr_pick(m_last, a_req);
        m_mode  = 1;
        m_hold  = 0;
        m_grant = 4'h0;
        m_grant[m_last] = 1'b1;
    endtask

    task automatic model_edge(input logic a_rst, input logic [3:0] a_req, input logic [23:0] a_pat);
        bit         tick;
        bit         leave;
        logic [3:0] others;
        if (a_rst) begin
            m_mode = 0; m_grant = 4'h0; m_leds = 6'h0; m_blink = 1'b0;
            m_hold = 0; m_last = NREQ - 1; m_since = 0;
            return;
        end
        tick = ((m_since % PER) == PER - 1);
        m_since++;
        case (m_mode)
            0: if (a_req != 4'h0) model_grant(a_req);
            1: begin
                others = a_req;
                others[m_last] = 1'b0;
                leave  = !a_req[m_last] || (m_hold == HOLD_TICKS && others != 4'h0);
                m_leds = a_pat[m_last * LED_W +: LED_W];
                if (tick) begin
                    m_blink = !m_blink;
                    if (m_hold < HOLD_TICKS) m_hold++;
                end
                if (leave) begin
                    m_mode  = 2;
                    m_grant = 4'h0;
                end
            end
            default: begin
                if (a_req != 4'h0) model_grant(a_req);
                else begin
                    m_mode = 0; m_leds = 6'h0; m_blink = 1'b0;
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk50);
        model_edge(rst, req, pattern);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [23:0] pat;
        int          n;
        logic [3:0]  g;
        logic [5:0]  l;
        logic        b;
        logic        y;
    } vec_t;

    vec_t tbl[24];

    initial begin
        tbl[0]  = '{1'b1, 4'hF, P1, 3,  4'h0, 6'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'hF, P1, 1,  4'h1, 6'h00, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 4'hB, P1, 6,  4'h1, 6'h11, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 4'hB, P1, 1,  4'h1, 6'h11, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 4'hB, P1, 1,  4'h0, 6'h11, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 4'hB, P1, 1,  4'h2, 6'h11, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 4'hB, P1, 1,  4'h2, 6'h22, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 4'hB, P1, 8,  4'h8, 6'h33, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 4'hB, P1, 1,  4'h8, 6'h33, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 4'hB, P1, 6,  4'h1, 6'h33, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 4'h0, P1, 1,  4'h0, 6'h11, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 4'h0, P1, 1,  4'h0, 6'h00, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 4'h4, P1, 1,  4'h4, 6'h00, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 4'h4, P1, 1,  4'h4, 6'h2A, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 4'h4, P1, 80, 4'h4, 6'h2A, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 4'h4, P1, 1,  4'h4, 6'h2A, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 4'h0, P1, 1,  4'h0, 6'h2A, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 4'h0, P1, 1,  4'h0, 6'h00, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 4'h2, P1, 1,  4'h2, 6'h00, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 4'h0, P1, 1,  4'h0, 6'h22, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 4'h0, P1, 1,  4'h0, 6'h00, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 4'h1, P2, 2,  4'h1, 6'h3F, 1'b0, 1'b1};
        tbl[22] = '{1'b1, 4'h1, P2, 1,  4'h0, 6'h00, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 4'h1, P2, 1,  4'h1, 6'h00, 1'b0, 1'b1};

        for (int i = 0; i < 24; i++) begin
            rst     = tbl[i].rst;
            req     = tbl[i].req;
            pattern = tbl[i].pat;
            repeat (tbl[i].n) step();
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
            check($sformatf("vec%0d_leds", i),  32'(leds),  32'(tbl[i].l));
            check($sformatf("vec%0d_blink", i), 32'(blink), 32'(tbl[i].b));
            check($sformatf("vec%0d_busy", i),  32'(busy),  32'(tbl[i].y));
        end

        // Pattern changes reach the LEDs one edge later while owned.
        step();
        check("pat_hold_3f", 32'(leds), 32'h3F);
        pattern[5:0] = 6'h05;
        check("pat_before_edge", 32'(leds), 32'h3F);
        step();
        check("pat_follow_05", 32'(leds), 32'h05);

        // Owner drops exactly on a tick edge: one handover cycle, one toggle.
        rst = 1'b1; req = 4'h8; pattern = P1;
        step();
        rst = 1'b0;
        step();
        check("droptick_grant", 32'(grant), 32'h8);
        step(); step();
        check("droptick_pre_blink", 32'(blink), 32'h0);
        req = 4'h0;
        step();
        check("droptick_grant0", 32'(grant), 32'h0);
        check("droptick_blink", 32'(blink), 32'h1);
        check("droptick_busy", 32'(busy), 32'h1);
        step();
        check("droptick_idle", 32'({grant, leds, blink, busy}), 32'h0);

        // Random traffic against the model, with occasional resets.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) req = 4'($urandom());
            if ($urandom_range(0, 3) == 0) pattern = 24'($urandom());
            rst = ($urandom_range(0, 499) == 0);
            step();
            check("rand_outputs", 32'({grant, leds, blink, busy}),
                  32'({m_grant, m_leds, m_blink, (m_mode != 0)}));
            if (!$onehot0(grant)) check("rand_onehot", 32'(grant), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
